regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have parameter NUM_RD, default 2: number of asynchronous read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2: number of synchronous write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored data only.
REQ-006 SHALL have parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero; 0 = register 0 is ordinary.
REQ-007 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-009 SHALL have port we_i  input  NUM_WR  per-port write enable.
REQ-010 SHALL have port waddr_i  input  NUM_WR*ADDR_WIDTH  write addresses; port k occupies slice k.
REQ-011 SHALL have port wdata_i  input  NUM_WR*DATA_WIDTH  write data; port k occupies slice k.
REQ-012 SHALL have port raddr_i  input  NUM_RD*ADDR_WIDTH  read addresses; port j occupies slice j.
REQ-013 SHALL have port rdata_o  output  NUM_RD*DATA_WIDTH  read data; port j occupies slice j.
REQ-014 SHALL have port clear_req_i  input  1  single-cycle request to zero the whole file.
REQ-015 SHALL have port clear_busy_o  output  1  high while the clear sequence runs.
REQ-016 SHALL have port clear_done_o  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-017 SHALL update register waddr_i[k] with wdata_i[k] on a rising clk edge when we_i[k]=1, except where REQ-018, REQ-019 or REQ-022 apply.
REQ-018 SHALL, when ZERO_REG=1, discard writes to address 0, and SHALL always return 0 for reads of address 0.
REQ-019 SHALL, when two write ports target the same address in one cycle, store the data of the higher-numbered port only.
REQ-020 SHALL drive rdata_o[j] combinationally from the register at raddr_i[j]; zero-cycle read latency.
REQ-021 SHALL, when BYPASS=1, forward wdata_i[k] to rdata_o[j] if we_i[k]=1, waddr_i[k]=raddr_i[j] and the write is not discarded by REQ-018; the higher-numbered port wins when several ports match; no forwarding in CLEAR.
REQ-022 SHALL implement a clear FSM with states IDLE, CLEAR and DONE; writes are ignored in CLEAR and accepted in IDLE and DONE.
REQ-023 SHALL, in IDLE with clear_req_i=1 at an edge, enter CLEAR with clear index = 0; clear_req_i SHALL be ignored in CLEAR and DONE.
REQ-024 SHALL, in CLEAR, zero register[index] at each edge and increment the index; after zeroing index DEPTH-1, go to DONE; CLEAR lasts exactly DEPTH cycles.
REQ-025 SHALL hold DONE for exactly one cycle, then return to IDLE.
REQ-026 SHALL drive clear_busy_o=1 only in CLEAR and clear_done_o=1 only in DONE; both are registered and glitch-free.
REQ-027 SHALL return 0 on every read port while in CLEAR, regardless of address.

Reset
REQ-028 SHALL, on rst_n=0, immediately and asynchronously zero all DEPTH registers, force the FSM to IDLE, reset the clear index to 0, and drive clear_busy_o=0 and clear_done_o=0.
REQ-029 SHALL abort an in-progress clear when rst_n is asserted during CLEAR; after release, the FSM is in IDLE with no clear_done_o pulse.
REQ-030 SHALL ignore all writes and clear requests while rst_n=0.

Verification
REQ-031 SHALL cover basic write/read: write 0xDEADBEEF to x5 via port 0, then read x5 on port 1 -> 0xDEADBEEF.
REQ-032 SHALL cover x0 handling: write 0x1234 to x0 -> reads 0 with ZERO_REG=1; reads 0x1234 after the edge with ZERO_REG=0.
REQ-033 SHALL cover write collision: port 0 writes 0xAAAA and port 1 writes 0x5555 to x7 in the same cycle -> x7 = 0x5555; same-cycle read of x7 with BYPASS=1 -> 0x5555.
REQ-034 SHALL cover bypass off: BYPASS=0, x3=0x11, write 0x22 to x3 -> same-cycle read 0x11, next cycle 0x22.
REQ-035 SHALL cover clear: pulse clear_req_i at edge N -> clear_busy_o high for cycles N+1..N+32, clear_done_o high at N+33, all registers read 0, and a write attempted during busy is lost.
REQ-036 SHALL cover reset mid-clear: assert rst_n=0 at cycle N+10 of a clear -> outputs 0 immediately; after release, FSM in IDLE with no clear_done_o pulse and all registers 0.

Source files
------------

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_mp                                                  |
// | Description : Multi-port register file with async reads, optional         |
// |               write-to-read bypass, hardwired x0 and a sequential clear.  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module regfile_mp #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_WR-1:0]            we_i,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr_i,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
   input  logic                         clear_req_i,
   output logic                         clear_busy_o,
   output logic                         clear_done_o
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic                  r_busy;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [ADDR_WIDTH-1:0] w_waddr [NUM_WR];
   logic [DATA_WIDTH-1:0] w_wdata [NUM_WR];
   logic [NUM_WR-1:0]     w_wr_ok;

   // A write is effective only out of reset, outside CLEAR, and not to a hardwired x0.
   for (genvar gk = 0; gk < NUM_WR; gk++) begin : g_wr
      assign w_waddr[gk] = waddr_i[gk*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata[gk] = wdata_i[gk*DATA_WIDTH +: DATA_WIDTH];
      assign w_wr_ok[gk] = rst_n && we_i[gk] && (r_state != S_CLEAR) &&
                           !((ZERO_REG != 0) && (w_waddr[gk] == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clear_req_i) begin
                  r_state <= S_CLEAR;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == {ADDR_WIDTH{1'b1}}) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Ascending port order lets the higher-numbered port win a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == S_CLEAR) begin
         r_mem[r_idx] <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (w_wr_ok[k]) begin
               r_mem[w_waddr[k]] <= w_wdata[k];
            end
         end
      end
   end

   for (genvar gj = 0; gj < NUM_RD; gj++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_raddr;
      logic [DATA_WIDTH-1:0] w_rdata;

      assign w_raddr = raddr_i[gj*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         w_rdata = r_mem[w_raddr];
         if (BYPASS != 0) begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (w_wr_ok[k] && (w_waddr[k] == w_raddr)) begin
                  w_rdata = w_wdata[k];
               end
            end
         end
         if (((ZERO_REG != 0) && (w_raddr == '0)) || (r_state == S_CLEAR)) begin
            w_rdata = '0;
         end
      end

      assign rdata_o[gj*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
   end

   assign clear_busy_o = r_busy;
   assign clear_done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_mp                                               |
// | Description : Bench for regfile_mp; default instance plus a BYPASS=0,     |
// |               ZERO_REG=0 instance sharing one stimulus stream.            |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_regfile_mp;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NW-1:0]    we;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic [NR*AW-1:0] raddr;
   logic             clear_req;
   logic [NR*DW-1:0] rd0, rd1;
   logic             busy0, done0, busy1, done1;

   int n_vec = 0;
   int n_err = 0;
   bit run = 1'b0;

   // golden register contents: m0 = default instance, m1 = BYPASS=0/ZERO_REG=0 instance
   logic [DW-1:0] m0 [DEPTH];
   logic [DW-1:0] m1 [DEPTH];
   bit            mclear;
   bit            mdone;
   int            mpos;

   always #5 clk = ~clk;

   regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW),
                .BYPASS(1), .ZERO_REG(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rd0), .clear_req_i(clear_req),
      .clear_busy_o(busy0), .clear_done_o(done0));

   regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW),
                .BYPASS(0), .ZERO_REG(0)) u_alt (
      .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rd1), .clear_req_i(clear_req),
      .clear_busy_o(busy1), .clear_done_o(done1));

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      mclear = 1'b0;
      mdone  = 1'b0;
      mpos   = 0;
   endtask

   function automatic logic [DW-1:0] exp_rd(input int inst, input logic [AW-1:0] a);
      logic [DW-1:0] e;
      bit zr, byp;
      zr  = (inst == 0);
      byp = (inst == 0);
      if (mclear) return '0;
      e = (inst == 0) ? m0[a] : m1[a];
      if (zr && a == 0) e = '0;
      if (byp && rst_n === 1'b1) begin
         for (int k = 0; k < NW; k++) begin
            if (we[k] && !(zr && waddr[k*AW +: AW] == 0) && waddr[k*AW +: AW] == a)
               e = wdata[k*DW +: DW];
         end
      end
      return e;
   endfunction

   always @(negedge rst_n) model_reset();

   // State-transition model: one clear step per edge, else apply writes then requests.
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         if (mclear) begin
            m0[mpos] = '0;
            m1[mpos] = '0;
            mpos++;
            if (mpos == DEPTH) begin
               mclear = 1'b0;
               mdone  = 1'b1;
            end
         end else begin
            for (int k = 0; k < NW; k++) begin
               if (we[k]) begin
                  if (waddr[k*AW +: AW] != 0) m0[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
                  m1[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
               end
            end
            if (mdone) mdone = 1'b0;
            else if (clear_req) begin
               mclear = 1'b1;
               mpos   = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         for (int j = 0; j < NR; j++) begin
            chk($sformatf("dut_rd%0d", j), rd0[j*DW +: DW], exp_rd(0, raddr[j*AW +: AW]));
            chk($sformatf("alt_rd%0d", j), rd1[j*DW +: DW], exp_rd(1, raddr[j*AW +: AW]));
         end
         chk("dut_busy", {31'd0, busy0}, {31'd0, mclear});
         chk("dut_done", {31'd0, done0}, {31'd0, mdone});
         chk("alt_busy", {31'd0, busy1}, {31'd0, mclear});
         chk("alt_done", {31'd0, done1}, {31'd0, mdone});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input int p, input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[p] = en;
      waddr[p*AW +: AW] = a;
      wdata[p*DW +: DW] = d;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      raddr[p*AW +: AW] = a;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0; clear_req = 1'b0;
      model_reset();
      step(); step();
      rst_n = 1'b1;
      run = 1'b1;
      #1;
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_rd", rd0[0 +: DW], 32'd0);

      // basic write/read
      wr(0, 1, 5, 32'hDEADBEEF); rd(1, 5);
      #1;
      chk("byp_x5", rd0[DW +: DW], 32'hDEADBEEF);
      chk("nobyp_x5", rd1[DW +: DW], 32'h0);
      step(); wr(0, 0, 0, 0);
      #1;
      chk("x5_dut", rd0[DW +: DW], 32'hDEADBEEF);
      chk("x5_alt", rd1[DW +: DW], 32'hDEADBEEF);

      // x0 handling
      wr(0, 1, 0, 32'h1234); rd(0, 0);
      #1;
      chk("x0_same_dut", rd0[0 +: DW], 32'h0);
      step(); wr(0, 0, 0, 0);
      #1;
      chk("x0_dut", rd0[0 +: DW], 32'h0);
      chk("x0_alt", rd1[0 +: DW], 32'h1234);

      // collision
      wr(0, 1, 7, 32'hAAAA); wr(1, 1, 7, 32'h5555); rd(0, 7);
      #1;
      chk("coll_byp", rd0[0 +: DW], 32'h5555);
      step(); wr(0, 0, 0, 0); wr(1, 0, 0, 0);
      #1;
      chk("coll_dut", rd0[0 +: DW], 32'h5555);
      chk("coll_alt", rd1[0 +: DW], 32'h5555);

      // bypass off
      wr(0, 1, 3, 32'h11); step();
      wr(0, 1, 3, 32'h22); rd(1, 3);
      #1;
      chk("nobyp_old", rd1[DW +: DW], 32'h11);
      chk("byp_new", rd0[DW +: DW], 32'h22);
      step(); wr(0, 0, 0, 0);
      #1;
      chk("nobyp_next", rd1[DW +: DW], 32'h22);

      // assorted traffic for the model
      for (int i = 1; i <= 8; i++) begin
         wr(0, 1, AW'(i + 8), 32'h01010101 * i);
         wr(1, 1, AW'(31 - i), 32'hF0F00000 + i);
         rd(0, AW'(i + 7)); rd(1, AW'(31 - i));
         step();
      end
      wr(0, 0, 0, 0); wr(1, 0, 0, 0);

      // clear sequence
      rd(0, 9); rd(1, 2);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy0) break;
         cnt++;
         #1;
         if (cnt == 5) clear_req = 1'b1;
         if (cnt == 6) clear_req = 1'b0;
         if (cnt == 20) begin
            wr(0, 1, 2, 32'hCAFE);
            #1 chk("clr_rd_zero", rd0[DW +: DW], 32'h0);
         end
         if (cnt == 21) wr(0, 0, 0, 0);
      end
      chk("clr_len", cnt, 32'd32);
      chk("clr_done", {31'd0, done0}, 32'd1);
      #1 clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      #1;
      chk("done_req_ign", {31'd0, busy0}, 32'd0);
      chk("done_gone", {31'd0, done0}, 32'd0);
      chk("lost_wr_x2", rd1[DW +: DW], 32'h0);
      for (int a = 0; a < DEPTH; a++) begin
         rd(0, AW'(a)); rd(1, AW'(31 - a));
         step();
      end

      // reset mid-clear
      wr(0, 1, 20, 32'h77); wr(1, 1, 21, 32'h88);
      step(); wr(0, 0, 0, 0); wr(1, 0, 0, 0);
      rd(0, 20); rd(1, 21);
      #1 chk("pre_x20", rd0[0 +: DW], 32'h77);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_busy", {31'd0, busy0}, 32'd0);
      chk("mid_done", {31'd0, done0}, 32'd0);
      chk("mid_x20", rd0[0 +: DW], 32'h0);
      chk("mid_x21_alt", rd1[DW +: DW], 32'h0);
      step(); step();
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done0 || busy0) cnt++;
      end
      chk("post_rst_quiet", cnt, 32'd0);
      #1;
      chk("post_x20", rd0[0 +: DW], 32'h0);
      chk("post_x21", rd1[DW +: DW], 32'h0);
      step();
      run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
